// File: rtl/cosine_share_arbiter.sv
// ---------------------------------------------------------------------------
// cosine_share_arbiter
//
// Shares one iterative cosine engine among N requesters with round-robin
// arbitration. On a grant, the block latches the winner's operands, pulses
// the engine start, and waits for a rising edge of the engine ready flag.
// It then returns the result to that requester with a one-cycle done pulse.
// A watchdog aborts a hung engine operation after TIMEOUT cycles and reports
// it on err.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   req        per-requester level request, held until the matching done
//   x_in       operand x per requester, requester i at [16i+15:16i]
//   y_in       operand y per requester, requester i at [8i+7:8i]
//   done       one-cycle completion pulse to the served requester
//   err        valid with done: 1 = operation aborted by the watchdog
//   res_out    result for the requester pulsed on done, held until next one
//   busy       high whenever the arbiter is not idle
//   grant_id   index of the requester currently being served
//   eng_start  one-cycle start pulse to the engine
//   eng_x      latched x operand to the engine
//   eng_y      latched y operand to the engine
//   eng_result engine result
//   eng_ready  engine completion flag (level or pulse)
// ---------------------------------------------------------------------------
module cosine_share_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [16*N-1:0]      x_in,
    input  logic [8*N-1:0]       y_in,
    output logic [N-1:0]         done,
    output logic                 err,
    output logic [15:0]          res_out,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 eng_start,
    output logic [15:0]          eng_x,
    output logic [7:0]           eng_y,
    input  logic [15:0]          eng_result,
    input  logic                 eng_ready
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_grant;
    logic [15:0]   r_x;
    logic [7:0]    r_y;
    logic [15:0]   r_res;
    logic          r_err;
    logic [CW-1:0] r_wdog;
    logic          r_rdy_q;
    logic          r_rdy_qq;
    logic [15:0]   r_result_q;

    logic          w_found;
    logic [IW-1:0] w_winner;
    logic [IW-1:0] w_idx;
    logic          w_complete;
    logic          w_timeout;

    // Round-robin search starting one past the last winner. The loop runs
    // from the farthest candidate to the nearest so the nearest set request
    // is the one that sticks.
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = IW'((int'(r_last) + k) % N);
            if (req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Completion is a rising edge seen on the registered ready samples, so a
    // ready left high by a previous job is never mistaken for a new one.
    assign w_complete = r_rdy_q & ~r_rdy_qq;
    assign w_timeout  = (r_wdog == CW'(TIMEOUT));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_found) w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_WAIT;
            S_WAIT:    if (w_complete || w_timeout) w_next = S_DELIVER;
            S_DELIVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        done = '0;
        if (r_state == S_DELIVER) done[r_grant] = 1'b1;
    end

    assign eng_start = (r_state == S_LAUNCH);
    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;
    assign eng_x     = r_x;
    assign eng_y     = r_y;
    assign res_out   = r_res;
    assign err       = r_err;

    // NOTE: state is written with non-blocking assignments so every register
    // in this block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the result sample is plain datapath that is only consumed
        // after a qualified ready edge, so it carries no reset.
        r_result_q <= eng_result;
        r_rdy_q    <= eng_ready;
        r_rdy_qq   <= r_rdy_q;
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= IW'(N - 1);
            r_grant  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_res    <= '0;
            r_err    <= 1'b0;
            r_wdog   <= '0;
            // Preload both samples so a ready already high at reset does not
            // look like a fresh edge.
            r_rdy_q  <= eng_ready;
            r_rdy_qq <= eng_ready;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_x     <= x_in[16*int'(w_winner) +: 16];
                        r_y     <= y_in[8*int'(w_winner) +: 8];
                    end
                end
                S_LAUNCH: begin
                    r_wdog <= '0;
                end
                S_WAIT: begin
                    if (w_complete) begin
                        r_res <= r_result_q;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cosine_share_arbiter.md
Name: cosine_share_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one iterative cosine engine among N requesters.
- The engine interface is start pulse in, operands x[15:0] and y[7:0] in, result[15:0] out, ready out.
- The block sits between the client blocks and the single engine instance.
- It latches the winning requester's operands, launches the engine, waits for completion, and returns the result to that requester only. A watchdog aborts hung operations.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 1023, maximum cycles to wait for engine completion before aborting; counter width $clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester level request. Held high until the matching done pulse.
- x_in  input  16*N  operand x per requester, requester i at bits [16i+15:16i].
- y_in  input  8*N  operand y per requester, requester i at bits [8i+7:8i].
- done  output  N  one-cycle completion pulse to the served requester.
- err  output  1  valid with done. 1 = operation aborted by timeout.
- res_out  output  16  result for the requester pulsed on done. Held until the next completion.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  $clog2(N)  index of the requester currently being served.
- eng_start  output  1  one-cycle start pulse to the engine.
- eng_x  output  16  latched x operand to the engine, stable from LAUNCH until the next grant.
- eng_y  output  8  latched y operand to the engine, stable from LAUNCH until the next grant.
- eng_result  input  16  engine result.
- eng_ready  input  1  engine done flag. May be a level or a pulse.

Behaviour:
Reset (clk edge with rst=1):
- State goes to IDLE.
- done=0, err=0, res_out=0, busy=0, grant_id=0, eng_start=0, eng_x=0, eng_y=0.
- Round-robin pointer last=N-1, so requester 0 has first priority.
- Watchdog counter cleared. The ready edge register is loaded with the current eng_ready.
- rst mid-operation abandons the job: no done is issued and the engine is not restarted.

FSM states: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE:
  - If req≠0, select the first set req bit searching (last+1) mod N upward with wrap.
  - Latch grant_id, eng_x and eng_y from that requester's slice, and set last=winner.
  - Go to LAUNCH.
  - If req=0, stay in IDLE.
- LAUNCH:
  - eng_start=1 for exactly this cycle. Clear the watchdog. Go to WAIT.
- WAIT:
  - Completion is detected as a rising edge of eng_ready: eng_ready=1 and the previous-cycle sample=0.
  - A ready that is already high from a prior job is not accepted.
  - On completion: res_out<=eng_result, err<=0, go to DELIVER.
  - Otherwise increment the watchdog. When it reaches TIMEOUT: res_out<=0, err<=1, go to DELIVER.
  - Completion and timeout in the same cycle: completion wins.
- DELIVER:
  - done[grant_id]=1 for this cycle only. Go to IDLE.
  - The requester must drop req on the edge that samples done.

Other rules:
- Latency from req rise (arbiter in IDLE) to eng_start: 1 cycle.
- Latency from eng_ready rise to done: 2 cycles.
- Minimum spacing between grants: 4 cycles plus engine latency.
- Operands are sampled only in the IDLE grant cycle. Later changes on x_in/y_in are ignored.
- req changes during LAUNCH, WAIT or DELIVER have no effect until the next IDLE cycle.
- A requester dropping req before done still receives done; its result is discarded by the requester.
- The served requester drops to lowest priority. It is re-served back-to-back only if it is the sole requester.
- Exactly one done bit is ever high in a cycle. done and eng_start are never high in the same cycle.
- busy=1 in LAUNCH, WAIT and DELIVER.

Test Plan:
- Bench engine stub: returns {x[7:0],y} with ready as a 1-cycle pulse L=10 cycles after start.
- Single request: rst pulse, then req=4'b0001, x0=16'h02BD, y0=8'h01.
  Required: eng_start 1 cycle after req, eng_x=16'h02BD, eng_y=8'h01, done=4'b0001 exactly 2 cycles after ready, res_out=16'hBD01, err=0.
- Contention: req=4'b1111 held with distinct operands (x_i=16'h0100*i, y_i=i).
  Required: grant order 0,1,2,3,0, each done carrying its own {x[7:0],y}, never two done bits high together.
- Round-robin fairness: after serving 1, req=4'b0011.
  Required: requester 0 is served before requester 1 is served again.
- Stale ready: stub holds ready level high continuously, then drops it and re-raises it 10 cycles after the new start.
  Required: no early done, result is taken from the new rising edge.
- Timeout: TIMEOUT=20, stub never asserts ready.
  Required: done 22 cycles after eng_start (20 watchdog cycles plus WAIT exit plus DELIVER), err=1, res_out=16'h0000; the next request is served normally afterwards.
- Reset mid-WAIT: rst for 1 cycle while in WAIT.
  Required: busy=0 and all outputs at reset values on the next cycle, no done pulse; the pending req=4'b0100 is then granted with grant_id=2.
